// File: rtl/distribuidor.sv
// distribuidor: registered 1-to-4 demultiplexer with per-channel handshake.
//
// A single producer presents one WIDTH-bit word per cycle on a valid/ready
// input port; SEL steers the word into a one-entry holding register for
// channel A, B, C or D. Each channel drains through its own valid/ready pair,
// so a stalled consumer only blocks words addressed to it.
//
// Ports:
//   clock                 rising-edge clock
//   nreset                synchronous active-low reset
//   Entrada  [WIDTH-1:0]  input word
//   SEL   [SEL_BITS-1:0]  destination channel (00=A, 01=B, 10=C, 11=D)
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   Saida_X  [WIDTH-1:0]  registered channel data, X in {A,B,C,D}
//   valid_X / ready_X     channel handshake
//   contagem_X [7:0]      per-channel transfer counters (optional)
//
// Optional feature: define DISTRIBUIDOR_CONT_EN to add the wrapping 8-bit
// transfer counters contagem_A..contagem_D.
module distribuidor #(
  parameter int WIDTH    = 4,
  parameter int SEL_BITS = 2
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic [WIDTH-1:0]    Entrada,
  input  logic [SEL_BITS-1:0] SEL,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    Saida_A,
  output logic [WIDTH-1:0]    Saida_B,
  output logic [WIDTH-1:0]    Saida_C,
  output logic [WIDTH-1:0]    Saida_D,
  output logic                valid_A,
  output logic                valid_B,
  output logic                valid_C,
  output logic                valid_D,
`ifdef DISTRIBUIDOR_CONT_EN
  output logic [7:0]          contagem_A,
  output logic [7:0]          contagem_B,
  output logic [7:0]          contagem_C,
  output logic [7:0]          contagem_D,
`endif
  input  logic                ready_A,
  input  logic                ready_B,
  input  logic                ready_C,
  input  logic                ready_D
);

  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [3:0]       ready_s;
  logic             xfer_s;

  assign ready_s = {ready_D, ready_C, ready_B, ready_A};

  // The selected slot can take a word if it is empty or draining this cycle.
  assign in_ready = nreset & (~valid_q[SEL] | ready_s[SEL]);
  assign xfer_s   = in_valid & in_ready;

`ifdef DISTRIBUIDOR_CONT_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  // Counter next state: increment (with natural 8-bit wrap) on each load.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (xfer_s) begin
      cnt_d[SEL] = cnt_q[SEL] + 8'd1;
    end else begin
      cnt_d[SEL] = cnt_q[SEL];
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign contagem_A = cnt_q[0];
  assign contagem_B = cnt_q[1];
  assign contagem_C = cnt_q[2];
  assign contagem_D = cnt_q[3];
`endif

  // Channel next state: drains clear valid first, then a load into the same
  // slot overrides it, so drain+load in one cycle keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
      if (valid_q[i] && ready_s[i]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
    if (xfer_s) begin
      data_d[SEL]  = Entrada;
      valid_d[SEL] = 1'b1;
    end else begin
      data_d[SEL]  = data_q[SEL];
    end
  end

  // Holding registers; reset discards any held word and clears the data.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign Saida_A = data_q[0];
  assign Saida_B = data_q[1];
  assign Saida_C = data_q[2];
  assign Saida_D = data_q[3];
  assign valid_A = valid_q[0];
  assign valid_B = valid_q[1];
  assign valid_C = valid_q[2];
  assign valid_D = valid_q[3];

endmodule

// File: doc/distribuidor.md
# distribuidor

- Registered 1-to-4 demultiplexer: the write-side counterpart of the 4-input roteador.
- Accepts one WIDTH-bit word per cycle on a valid/ready input port and steers it to output channel A, B, C or D according to SEL.
- Each channel has a one-entry holding register with its own valid/ready handshake, so a stalled sink blocks only traffic addressed to it.
- Sits between a single producer and four independent consumers in the datapath.

## Interface

Parameters:
- WIDTH, 4: data width of input and of every output channel.
- SEL_BITS, 2: width of SEL. Fixed at 2 (four channels); other values are unsupported.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- nreset  input  1  reset, synchronous and active-low.
- Entrada  input  WIDTH  input word.
- SEL  input  SEL_BITS  destination: 00=A, 01=B, 10=C, 11=D. Sampled together with Entrada.
- in_valid  input  1  Entrada/SEL are valid this cycle.
- in_ready  output  1  distribuidor can accept the word addressed by the current SEL.
- Saida_A, Saida_B, Saida_C, Saida_D  output  WIDTH  registered channel data.
- valid_A, valid_B, valid_C, valid_D  output  1  channel holds an undelivered word.
- ready_A, ready_B, ready_C, ready_D  input  1  consumer accepts the channel word this cycle.

## Operation

- Per channel X: holding register Saida_X and flag valid_X.
- Input transfer: occurs in a cycle where in_valid && in_ready.
- Channel drain: valid_X && ready_X in the same cycle.
- in_ready (combinational): nreset && (!valid_S || ready_S), where S is the channel selected by the current SEL.
  - in_ready depends on SEL and ready_S; it does not depend on in_valid.
- At the rising edge after an input transfer to channel S: Saida_S <= Entrada, valid_S <= 1.
- At the rising edge after a drain of X with no transfer into X: valid_X <= 0. Saida_X keeps its last value and is not cleared.
- Drain of X and transfer into X in the same cycle: Saida_X is reloaded and valid_X stays 1. No bubble, no loss.
- Channels not addressed by SEL are unaffected by input traffic. Their drains proceed independently, in parallel.
- Once valid_X is 1, Saida_X must stay constant until the drain cycle.
- A word is never duplicated or dropped. Every accepted word produces exactly one drain on its channel.
- SEL is don't-care when in_valid is 0.

## Timing

- Reset (nreset low at a rising edge):
  - all valid_X = 0, all Saida_X = 0.
  - in_ready = 0 while nreset is low; it returns to 1 in the first cycle nreset is high.
  - Any word held in a channel when reset occurs is discarded.
- Latency: a word accepted in cycle N appears on Saida_S with valid_S = 1 in cycle N+1.
  - It can be drained in cycle N+1 at the earliest.
- Throughput: one word per cycle into any channel, including back-to-back words to the same channel, as long as that channel's ready is high.
- Backpressure: if valid_S = 1 and ready_S = 0, in_ready = 0 for that SEL.
  - The producer must hold in_valid, Entrada and SEL until it sees in_ready = 1.
  - Changing SEL to a free channel raises in_ready in the same cycle.
- Drain and reset in the same edge: reset wins and the channel ends empty.

## Configuration

- DISTRIBUIDOR_CONT_EN defined:
  - Adds four output ports contagem_A..contagem_D (8 bits each).
  - Each counter counts input transfers into its channel and wraps from 255 to 0.
  - Counters reset to 0 and update at the same edge that loads the channel.
- DISTRIBUIDOR_CONT_EN undefined:
  - These ports and counters do not exist.
  - All other behaviour is identical.

## Test plan

- Reset: nreset low for 2 cycles with in_valid = 1 -> in_ready = 0, all valid_X = 0, all Saida_X = 0. First cycle after release -> in_ready = 1.
- Basic steering: with all ready = 0, send Entrada = 4'h3/SEL = 00, 4'h5/01, 4'hA/10, 4'hF/11 on consecutive cycles -> each valid set one cycle after its transfer. Final state: Saida_A = 3, Saida_B = 5, Saida_C = A, Saida_D = F, all valid = 1.
- Backpressure: channel B full with ready_B = 0, present SEL = 01, Entrada = 4'h7 for 3 cycles -> in_ready = 0 and Saida_B unchanged. Raise ready_B -> in_ready = 1 the same cycle; next cycle Saida_B = 7 with valid_B = 1.
- Simultaneous drain and load: channel C holds 4'h2 with ready_C = 1, transfer 4'h9 to SEL = 10 in the same cycle -> next cycle valid_C = 1, Saida_C = 9; exactly one drain of 2 is observed.
- Streaming: 16 consecutive words 0..F to SEL = 11 with ready_D tied high -> in_ready stays 1, 16 drains in order 0..F, no bubbles.
- Counter (DISTRIBUIDOR_CONT_EN): 257 transfers to channel A -> contagem_A = 1, other counters 0. Reset mid-stream -> all counters 0.
